// File: rtl/frame_fetch_pkg.sv
// Shared constants and FSM state type for the port-B frame fetch sequencer.
// The region bases are also used by the memory stage's address decode.
package frame_fetch_pkg;
  localparam int FRAME_WORDS = 90000;
  localparam int RAM_BASE    = 90300;
  localparam int SIN_BASE    = 90000;
  localparam int CNT_W       = 17;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
endpackage

// File: rtl/frame_fetch_ctrl_sync_fifo.sv
// Small synchronous FIFO with a combinational head word and an occupancy count.
// Flush has the same effect as reset but is driven by the controller.
module sync_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rptr_q];
  assign rd        = rd_en_i & ~empty_o;
  // a write into a full FIFO is only legal when the head leaves the same cycle
  assign wr        = wr_en_i & (~full_o | rd);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= nxt(wptr_q);
      if (rd) rptr_q <= nxt(rptr_q);
      case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/frame_fetch_ctrl.sv
// Port-B frame sweep sequencer: issues one read per cycle under FIFO credit,
// tracks the fixed read latency with a valid shift register, streams pixels out.
module frame_fetch_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 24,
  parameter int FRAME_WORDS = frame_fetch_pkg::FRAME_WORDS,
  parameter int RAM_BASE    = frame_fetch_pkg::RAM_BASE,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_sel,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_rdata_b,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);
  import frame_fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic [CNT_W-1:0]    issue_q, issue_d, accept_q, accept_d;
  logic [RD_LAT-1:0]   vld_sr_q, last_sr_q;
  logic [CW-1:0]       outst, fifo_cnt;
  logic                fifo_full, fifo_empty, credit, issue_go, flush, pop;
  logic [DATA_W:0]     fifo_rd;

  always_comb begin
    outst = '0;
    for (int i = 0; i < RD_LAT; i++) outst = outst + CW'(vld_sr_q[i]);
  end

  // every in-flight read already owns a FIFO slot, so a write can never overflow
  assign credit = ~fifo_full &&
                  (({1'b0, outst} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH));
  assign pop    = ~fifo_empty & pix_ready;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    issue_d  = issue_q;
    accept_d = accept_q;
    issue_go = 1'b0;
    flush    = 1'b0;
    if (pop && accept_q != CNT_W'(FRAME_WORDS)) accept_d = accept_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = FETCH;
          base_d   = src_sel ? ADDR_W'(RAM_BASE) : '0;
          issue_d  = '0;
          accept_d = '0;
        end
      end
      FETCH: begin
        if (credit) begin
          issue_go = 1'b1;
          addr_d   = base_q + ADDR_W'(issue_q);
          issue_d  = issue_q + 1'b1;
          if (issue_q == CNT_W'(FRAME_WORDS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept_d == CNT_W'(FRAME_WORDS)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      flush    = 1'b1;
      issue_go = 1'b0;
    end
    if (state_d == IDLE) addr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      addr_q    <= '0;
      issue_q   <= '0;
      accept_q  <= '0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      base_q   <= base_d;
      addr_q   <= addr_d;
      issue_q  <= issue_d;
      accept_q <= accept_d;
      if (flush) begin
        vld_sr_q  <= '0;
        last_sr_q <= '0;
      end else begin
        vld_sr_q  <= (vld_sr_q << 1) | RD_LAT'(issue_go);
        last_sr_q <= (last_sr_q << 1) |
                     RD_LAT'(issue_go && issue_q == CNT_W'(FRAME_WORDS - 1));
      end
    end
  end

  sync_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .wr_en_i   (vld_sr_q[RD_LAT-1]),
    .wr_data_i ({last_sr_q[RD_LAT-1], mem_rdata_b}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_cnt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign mem_addr_b = addr_q;
  assign pix_valid  = ~fifo_empty;
  assign pix_data   = fifo_rd[DATA_W-1:0];
  assign pix_last   = ~fifo_empty & fifo_rd[DATA_W];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
endmodule
